// File: rtl/timer_axil_regs.sv
// AXI4-Lite register block for a timer core: CTRL pulses, LOAD, live COUNT, RW1C STATUS.
// Define TIMER_IRQ_MASK_EN to add an IRQ_EN register at 0x10 that gates irq_out.
module timer_axil_regs #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic              start,
   output logic              stop,
   output logic [31:0]       load_val,
   input  logic [31:0]       cur_count,
   input  logic              timer_irq,
   output logic              irq_out
);

   localparam int WW = ADDR_W - 2;
   localparam logic [WW-1:0] A_CTRL   = WW'(0);
   localparam logic [WW-1:0] A_LOAD   = WW'(1);
   localparam logic [WW-1:0] A_COUNT  = WW'(2);
   localparam logic [WW-1:0] A_STATUS = WW'(3);
   localparam logic [WW-1:0] A_IRQ_EN = WW'(4);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t     wstate_q, wstate_d;
   rstate_t     rstate_q, rstate_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        start_q, start_d;
   logic        stop_q, stop_d;
   logic [31:0] load_q, load_d;
   logic        pend_q, pend_d;
   logic        irq_prev_q;
   logic        irq_out_q, irq_out_d;
   logic        en_q, en_d;
   logic        wr_acc, rd_acc, clr_pend;

   logic [WW-1:0] aw_word, ar_word;
   assign aw_word = s_awaddr[ADDR_W-1:2];
   assign ar_word = s_araddr[ADDR_W-1:2];

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

   function automatic logic is_mapped(input logic [WW-1:0] w);
      logic m;
      m = (w == A_CTRL) || (w == A_LOAD) || (w == A_COUNT) || (w == A_STATUS);
`ifdef TIMER_IRQ_MASK_EN
      m = m || (w == A_IRQ_EN);
`endif
      return m;
   endfunction

   // Write channel: address and data are only taken together, one response outstanding.
   always_comb begin
      wstate_d = wstate_q;
      bresp_d  = bresp_q;
      start_d  = 1'b0;
      stop_d   = 1'b0;
      load_d   = load_q;
      en_d     = en_q;
      clr_pend = 1'b0;
      wr_acc   = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (!rst && s_awvalid && s_wvalid) begin
               wr_acc   = 1'b1;
               wstate_d = W_RESP;
               bresp_d  = is_mapped(aw_word) ? RESP_OKAY : RESP_SLVERR;
            end
         end
         W_RESP: begin
            if (s_bready) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
      if (wr_acc) begin
         if (aw_word == A_CTRL) begin
            start_d = s_wstrb[0] & s_wdata[0];
            stop_d  = s_wstrb[0] & s_wdata[1];
         end
         if (aw_word == A_LOAD) begin
            for (int b = 0; b < 4; b++)
               if (s_wstrb[b]) load_d[8*b +: 8] = s_wdata[8*b +: 8];
         end
         if (aw_word == A_STATUS) clr_pend = s_wstrb[0] & s_wdata[0];
`ifdef TIMER_IRQ_MASK_EN
         if (aw_word == A_IRQ_EN && s_wstrb[0]) en_d = s_wdata[0];
`endif
      end
   end

   // A new timer_irq edge beats a simultaneous software clear.
   always_comb begin
      pend_d = (timer_irq & ~irq_prev_q) | (pend_q & ~clr_pend);
`ifdef TIMER_IRQ_MASK_EN
      irq_out_d = pend_q & en_q;
`else
      irq_out_d = pend_q;
`endif
   end

   // Read channel: data is captured at accept so it reflects pre-write register state.
   always_comb begin
      rstate_d = rstate_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rd_acc   = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            if (!rst && s_arvalid) begin
               rd_acc   = 1'b1;
               rstate_d = R_DATA;
            end
         end
         R_DATA: begin
            if (s_rready) rstate_d = R_IDLE;
         end
         default: rstate_d = R_IDLE;
      endcase
      if (rd_acc) begin
         rresp_d = RESP_OKAY;
         rdata_d = 32'h0;
         case (ar_word)
            A_CTRL:   rdata_d = 32'h0;
            A_LOAD:   rdata_d = load_q;
            A_COUNT:  rdata_d = cur_count;
            A_STATUS: rdata_d = {31'h0, pend_q};
`ifdef TIMER_IRQ_MASK_EN
            A_IRQ_EN: rdata_d = {31'h0, en_q};
`endif
            default:  rresp_d = RESP_SLVERR;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate_q   <= W_IDLE;
         rstate_q   <= R_IDLE;
         bresp_q    <= 2'b00;
         rresp_q    <= 2'b00;
         rdata_q    <= 32'h0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         load_q     <= 32'h0;
         pend_q     <= 1'b0;
         irq_prev_q <= 1'b0;
         irq_out_q  <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         wstate_q   <= wstate_d;
         rstate_q   <= rstate_d;
         bresp_q    <= bresp_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         load_q     <= load_d;
         pend_q     <= pend_d;
         irq_prev_q <= timer_irq;
         irq_out_q  <= irq_out_d;
         en_q       <= en_d;
      end
   end

   assign s_awready = wr_acc;
   assign s_wready  = wr_acc;
   assign s_bvalid  = (wstate_q == W_RESP);
   assign s_bresp   = bresp_q;
   assign s_arready = !rst && (rstate_q == R_IDLE);
   assign s_rvalid  = (rstate_q == R_DATA);
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;
   assign start     = start_q;
   assign stop      = stop_q;
   assign load_val  = load_q;
   assign irq_out   = irq_out_q;

endmodule

// File: doc/timer_axil_regs.md
TIMER_AXIL_REGS -- requirements
Module: timer_axil_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, AXI4-Lite byte address width.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have AXI4-Lite write ports: s_awaddr in ADDR_W; s_awvalid in 1; s_awready out 1; s_wdata in 32; s_wstrb in 4; s_wvalid in 1; s_wready out 1; s_bresp out 2; s_bvalid out 1; s_bready in 1.
REQ-005 SHALL have AXI4-Lite read ports: s_araddr in ADDR_W; s_arvalid in 1; s_arready out 1; s_rdata out 32; s_rresp out 2; s_rvalid out 1; s_rready in 1.
REQ-006 SHALL have timer-side ports: start out 1, one-cycle pulse; stop out 1, one-cycle pulse; load_val out 32, reload value; cur_count in 32, live count; timer_irq in 1, level from timer core.
REQ-007 SHALL have port irq_out, output, 1, registered interrupt to the system.

Function
REQ-008 SHALL implement this map, word-aligned, addr[1:0] ignored: 0x00 CTRL (WO), 0x04 LOAD (RW), 0x08 COUNT (RO), 0x0C STATUS (RW1C).
REQ-009 SHALL use a write FSM: W_IDLE -> W_RESP when s_awvalid and s_wvalid are both high; W_RESP -> W_IDLE when s_bready is high.
REQ-010 SHALL assert s_awready and s_wready together for exactly the one accept cycle; a lone awvalid or wvalid SHALL be held and not accepted.
REQ-011 SHALL assert s_bvalid the cycle after accept and hold it, bresp stable, until s_bready; no new write accepted while s_bvalid is high.
REQ-012 SHALL use a read FSM: R_IDLE -> R_DATA on s_arvalid (s_arready high that cycle); R_DATA -> R_IDLE on s_rready; s_rdata/s_rresp SHALL be stable while s_rvalid is high.
REQ-013 SHALL sample COUNT data on the arvalid accept cycle, so s_rdata equals cur_count from that cycle.
REQ-014 SHALL pulse start for one cycle, the cycle after accept, when a CTRL write has wdata[0]=1 and wstrb[0]=1; wdata[1]=1 SHALL likewise pulse stop; both set SHALL pulse both.
REQ-015 SHALL update LOAD bytewise per s_wstrb; load_val SHALL equal the LOAD register.
REQ-016 SHALL set STATUS[0] (irq_pend) on the rising edge of timer_irq, detected with one registered previous sample.
REQ-017 SHALL clear irq_pend on a STATUS write with wdata[0]=1 and wstrb[0]=1; if a set edge coincides with the clear, set SHALL win.
REQ-018 SHALL read CTRL as 0 and unused bits as 0.
REQ-019 SHALL return resp 2'b10 (SLVERR) for unmapped addresses, with no side effects, and read data 0; mapped accesses SHALL return 2'b00; writes to COUNT SHALL be ignored with OKAY.
REQ-020 SHALL drive irq_out as a register of irq_pend (one-cycle latency).
REQ-021 SHALL handle simultaneous read and write independently; a read of LOAD/STATUS in the same cycle as a write SHALL return the pre-write value.

Reset
REQ-022 SHALL, while rst is high, force: both FSMs idle, all ready/valid outputs 0, s_bresp/s_rresp/s_rdata 0, start/stop 0, LOAD 0, irq_pend 0, irq_out 0, edge register 0.
REQ-023 SHALL abandon any in-flight transaction on reset without issuing a response.

Configuration
REQ-024 SHALL, with TIMER_IRQ_MASK_EN defined, add IRQ_EN at 0x10 (RW, bit0, reset 0) and drive irq_out as registered irq_pend AND IRQ_EN[0]; irq_pend SHALL still set while masked.
REQ-025 SHALL, without TIMER_IRQ_MASK_EN, treat 0x10 as unmapped (SLVERR) and drive irq_out from irq_pend alone.

Verification
REQ-026 SHALL cover: write LOAD=0xDEAD_BEEF, strb 4'hF -> OKAY, load_val=0xDEADBEEF, LOAD readback 0xDEADBEEF.
REQ-027 SHALL cover: write LOAD 0x1122_3344 with strb 4'b0101 over 0xDEADBEEF -> LOAD=0xDE22BE44.
REQ-028 SHALL cover: write CTRL=0x3 -> start and stop each high exactly one cycle, same cycle; CTRL read -> 0.
REQ-029 SHALL cover: timer_irq 0->1 -> STATUS=1, irq_out high 1 cycle later; write STATUS=1 while timer_irq stays 1 -> STATUS=0, irq_out low, no re-set.
REQ-030 SHALL cover: awvalid held 3 cycles before wvalid, bready low 4 cycles -> accept only when both valid, bvalid held 4 cycles, resp stable.
REQ-031 SHALL cover: read 0x14 -> rresp 2'b10, rdata 0; with TIMER_IRQ_MASK_EN undefined, read 0x10 -> SLVERR.
